// File: rtl/booth_r4_seq_mul_pkg.sv
// Shared types for the radix-4 Booth sequential multiplier: controller states
// and the partial-product selector produced by the recoder.
package booth_r4_seq_mul_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  typedef enum logic [2:0] {
    PP_ZERO = 3'd0,
    PP_POS1 = 3'd1,
    PP_POS2 = 3'd2,
    PP_NEG1 = 3'd3,
    PP_NEG2 = 3'd4
  } pp_sel_e;

  // Bits are {q[i+1], q[i], q[i-1]} of the multiplier window.
  function automatic pp_sel_e booth_select(input logic [2:0] bits);
    pp_sel_e sel;
    case (bits)
      3'b000, 3'b111: sel = PP_ZERO;
      3'b001, 3'b010: sel = PP_POS1;
      3'b011:         sel = PP_POS2;
      3'b100:         sel = PP_NEG2;
      default:        sel = PP_NEG1;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/booth_r4_seq_mul_cla.sv
// Parallel-prefix carry-lookahead adder with carry-in; the carry-in carries
// the +1 that completes two's-complement negation of the partial product.
module booth_r4_cla #(
  parameter int W = 34
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum
);

  localparam int LV = $clog2(W);

  logic [W-1:0] p0;
  logic [W-2:0] g0;
  logic [W-2:0] g_lv [LV+1];
  logic [W-2:0] p_lv [LV+1];
  logic [W-1:0] carry;

  for (genvar gi = 0; gi < W; gi++) begin : g_bit
    assign p0[gi] = a[gi] ^ b[gi];
    // The top bit's generate only feeds a carry-out nobody consumes.
    if (gi == 0) begin : g_lsb
      assign g0[gi] = (a[gi] & b[gi]) | (p0[gi] & cin);
    end else if (gi < W - 1) begin : g_mid
      assign g0[gi] = a[gi] & b[gi];
    end
  end

  always_comb begin
    g_lv[0] = g0;
    p_lv[0] = p0[W-2:0];
    for (int lv = 0; lv < LV; lv++) begin
      g_lv[lv+1] = g_lv[lv];
      p_lv[lv+1] = p_lv[lv];
      for (int i = (1 << lv); i < W - 1; i++) begin
        g_lv[lv+1][i] = g_lv[lv][i] | (p_lv[lv][i] & g_lv[lv][i-(1<<lv)]);
        p_lv[lv+1][i] = p_lv[lv][i] & p_lv[lv][i-(1<<lv)];
      end
    end
  end

  assign carry = {g_lv[LV], cin};
  assign sum   = p0 ^ carry;

endmodule

// File: rtl/booth_r4_seq_mul_recoder.sv
// Radix-4 Booth recoder: turns a 3-bit multiplier window into the controls
// that shape the partial product (zero, double, negate).
module booth_r4_recoder
  import booth_r4_seq_mul_pkg::*;
(
  input  logic [2:0] bits,
  output logic       sel_zero,
  output logic       sel_2x,
  output logic       neg
);

  pp_sel_e sel;

  always_comb begin
    sel      = booth_select(bits);
    sel_zero = (sel == PP_ZERO);
    sel_2x   = (sel == PP_POS2) || (sel == PP_NEG2);
    neg      = (sel == PP_NEG1) || (sel == PP_NEG2);
  end

endmodule

// File: rtl/booth_r4_seq_mul.sv
// Sequential signed multiplier, radix-4 Booth, two multiplier bits per cycle.
// start/done/clear handshake; product held in DONE until cleared.
module booth_r4_seq_mul
  import booth_r4_seq_mul_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 op_start,
  input  logic                 op_clear,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 op_done,
  output logic [2*WIDTH-1:0]   result
);

  localparam int UW    = WIDTH + 2;
  localparam int ITER  = WIDTH / 2;
  localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   m_q, m_d;
  logic [UW-1:0]      u_q, u_d;
  logic [WIDTH-1:0]   l_q, l_d;
  logic               x_q, x_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               done_q, done_d;
  logic [2*WIDTH-1:0] result_q, result_d;

  logic               sel_zero, sel_2x, neg;
  logic [UW-1:0]      m_ext, pp_mag, pp, sum;

  booth_r4_recoder u_recoder (
    .bits     ({l_q[1], l_q[0], x_q}),
    .sel_zero (sel_zero),
    .sel_2x   (sel_2x),
    .neg      (neg)
  );

  // Negation is ~PP here plus the adder carry-in, so no incrementer is needed.
  always_comb begin
    m_ext  = {{2{m_q[WIDTH-1]}}, m_q};
    pp_mag = sel_2x ? (m_ext << 1) : m_ext;
    if (sel_zero) begin
      pp_mag = '0;
    end
    pp = neg ? ~pp_mag : pp_mag;
  end

  booth_r4_cla #(.W(UW)) u_cla (
    .a   (u_q),
    .b   (pp),
    .cin (neg),
    .sum (sum)
  );

  always_comb begin
    state_d  = state_q;
    m_d      = m_q;
    u_d      = u_q;
    l_d      = l_q;
    x_d      = x_q;
    cnt_d    = cnt_q;
    done_d   = done_q;
    result_d = result_q;
    if (op_clear) begin
      state_d  = ST_IDLE;
      done_d   = 1'b0;
      result_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (op_start) begin
            state_d = ST_EXEC;
            m_d     = multiplicand;
            l_d     = multiplier;
            u_d     = '0;
            x_d     = 1'b0;
            cnt_d   = '0;
          end
        end
        ST_EXEC: begin
          // Arithmetic shift of {S, L, x} right by two.
          u_d   = {{2{sum[UW-1]}}, sum[UW-1:2]};
          l_d   = {sum[1:0], l_q[WIDTH-1:2]};
          x_d   = l_q[1];
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(ITER - 1)) begin
            state_d = ST_DONE;
          end
        end
        ST_DONE: begin
          if (!done_q) begin
            done_d   = 1'b1;
            result_d = {u_q[WIDTH-1:0], l_q};
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      m_q      <= '0;
      u_q      <= '0;
      l_q      <= '0;
      x_q      <= 1'b0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      m_q      <= m_d;
      u_q      <= u_d;
      l_q      <= l_d;
      x_q      <= x_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  assign op_done = done_q;
  assign result  = result_q;

endmodule

// File: tb/tb_booth_r4_seq_mul.sv
// Self-checking bench for booth_r4_seq_mul: directed edge cases, handshake
// scenarios and randomized products checked against plain signed multiplication.
module tb_booth_r4_seq_mul;

  localparam int W   = 32;
  localparam int LAT = W / 2 + 1;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          op_start;
  logic          op_clear;
  logic [W-1:0]  multiplicand;
  logic [W-1:0]  multiplier;
  logic          op_done;
  logic [2*W-1:0] result;

  int n_cmp = 0;
  int n_bad = 0;

  booth_r4_seq_mul #(.WIDTH(W)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .op_start     (op_start),
    .op_clear     (op_clear),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .op_done      (op_done),
    .result       (result)
  );

  always #5 clk = ~clk;

  function automatic logic [2*W-1:0] ref_product(input logic [W-1:0] m, input logic [W-1:0] q);
    logic signed [W-1:0] ms, qs;
    longint a, b;
    ms = m;
    qs = q;
    a  = ms;
    b  = qs;
    return 64'(a * b);
  endfunction

  // Stimulus helpers: all tasks leave time at 1 unit after a rising edge.
  task automatic start_op(input logic [W-1:0] m, input logic [W-1:0] q);
    multiplicand = m;
    multiplier   = q;
    op_start     = 1'b1;
    @(posedge clk); #1;
    op_start     = 1'b0;
  endtask

  task automatic do_clear();
    op_clear = 1'b1;
    @(posedge clk); #1;
    op_clear = 1'b0;
  endtask

  // Returns the number of edges after the start edge until op_done, or -1.
  // Operand inputs are scrambled every cycle; op_start is pulsed at poke_at.
  task automatic wait_done(input int poke_at, output int n);
    n = -1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      multiplicand = $urandom;
      multiplier   = $urandom;
      op_start     = (c == poke_at);
      if (op_done) begin
        n = c;
        break;
      end
    end
    op_start = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; op_start = 1'b0; op_clear = 1'b0;
    multiplicand = '0; multiplier = '0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (op_done !== 1'b0 || result !== '0) begin
      n_bad++;
      $display("FAIL reset_values: op_done=%b result=%h required op_done=0 result=0", op_done, result);
    end
    reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    logic [W-1:0] ms [6];
    logic [W-1:0] qs [6];
    logic [2*W-1:0] req [6];
    int n;
    ms[0] = 32'd7;          qs[0] = 32'hFFFF_FFFD; req[0] = 64'hFFFF_FFFF_FFFF_FFEB;
    ms[1] = 32'h8000_0000;  qs[1] = 32'h8000_0000; req[1] = 64'h4000_0000_0000_0000;
    ms[2] = 32'h7FFF_FFFF;  qs[2] = 32'h7FFF_FFFF; req[2] = 64'h3FFF_FFFF_0000_0001;
    ms[3] = 32'hFFFF_FFFF;  qs[3] = 32'hFFFF_FFFF; req[3] = 64'h0000_0000_0000_0001;
    ms[4] = 32'h0;          qs[4] = 32'h1234_5678; req[4] = 64'h0;
    ms[5] = 32'h8000_0000;  qs[5] = 32'h0000_0002; req[5] = 64'hFFFF_FFFF_0000_0000;
    for (int i = 0; i < 6; i++) begin
      start_op(ms[i], qs[i]);
      wait_done(0, n);
      n_cmp++;
      if (n != LAT) begin
        n_bad++;
        $display("FAIL directed_latency[%0d]: cycles=%0d required=%0d", i, n, LAT);
      end
      n_cmp++;
      if (result !== req[i]) begin
        n_bad++;
        $display("FAIL directed_product[%0d]: M=%h Q=%h result=%h required=%h", i, ms[i], qs[i], result, req[i]);
      end
      if (i == 0) begin
        for (int h = 0; h < 10; h++) begin
          @(posedge clk); #1;
          n_cmp++;
          if (op_done !== 1'b1 || result !== req[0]) begin
            n_bad++;
            $display("FAIL done_hold[%0d]: op_done=%b result=%h required op_done=1 result=%h", h, op_done, result, req[0]);
          end
        end
      end
      do_clear();
      n_cmp++;
      if (op_done !== 1'b0 || result !== '0) begin
        n_bad++;
        $display("FAIL clear_after_done[%0d]: op_done=%b result=%h required op_done=0 result=0", i, op_done, result);
      end
    end
  endtask

  task automatic test_clear_mid_exec();
    int saw = 0;
    start_op(32'h1234_5678, 32'h9ABC_DEF0);
    repeat (8) @(posedge clk);
    #1;
    do_clear();
    n_cmp++;
    if (op_done !== 1'b0 || result !== '0) begin
      n_bad++;
      $display("FAIL clear_mid_exec: op_done=%b result=%h required op_done=0 result=0", op_done, result);
    end
    for (int c = 0; c < 25; c++) begin
      @(posedge clk); #1;
      if (op_done) saw++;
    end
    n_cmp++;
    if (saw != 0) begin
      n_bad++;
      $display("FAIL clear_discards_op: done_cycles=%0d required=0", saw);
    end
  endtask

  task automatic test_clear_with_start();
    int saw = 0;
    multiplicand = 32'd5;
    multiplier   = 32'd6;
    op_start     = 1'b1;
    op_clear     = 1'b1;
    @(posedge clk); #1;
    op_start     = 1'b0;
    op_clear     = 1'b0;
    for (int c = 0; c < 25; c++) begin
      @(posedge clk); #1;
      if (op_done) saw++;
    end
    n_cmp++;
    if (saw != 0 || result !== '0) begin
      n_bad++;
      $display("FAIL clear_priority: done_cycles=%0d result=%h required 0 and 0", saw, result);
    end
  endtask

  task automatic test_start_ignored();
    logic [2*W-1:0] req;
    int n;
    req = ref_product(32'hDEAD_BEEF, 32'h0BAD_F00D);
    start_op(32'hDEAD_BEEF, 32'h0BAD_F00D);
    wait_done(5, n);
    n_cmp++;
    if (n != LAT || result !== req) begin
      n_bad++;
      $display("FAIL start_in_exec: cycles=%0d result=%h required cycles=%0d result=%h", n, result, LAT, req);
    end
    multiplicand = 32'h1111_1111;
    multiplier   = 32'h2222_2222;
    op_start     = 1'b1;
    @(posedge clk); #1;
    op_start     = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    n_cmp++;
    if (op_done !== 1'b1 || result !== req) begin
      n_bad++;
      $display("FAIL start_in_done: op_done=%b result=%h required op_done=1 result=%h", op_done, result, req);
    end
    do_clear();
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] m, q;
    int n;
    for (int k = 0; k < 2; k++) begin
      m = $urandom;
      q = $urandom;
      start_op(m, q);
      wait_done(0, n);
      n_cmp++;
      if (n != LAT || result !== ref_product(m, q)) begin
        n_bad++;
        $display("FAIL back_to_back[%0d]: cycles=%0d result=%h required cycles=%0d result=%h", k, n, result, LAT, ref_product(m, q));
      end
      do_clear();
    end
  endtask

  task automatic test_random();
    logic [W-1:0] edge_vals [5];
    logic [W-1:0] m, q;
    int n;
    edge_vals[0] = 32'h8000_0000;
    edge_vals[1] = 32'h7FFF_FFFF;
    edge_vals[2] = 32'hFFFF_FFFF;
    edge_vals[3] = 32'h0;
    edge_vals[4] = 32'h1;
    for (int k = 0; k < 30; k++) begin
      m = ($urandom_range(3) == 0) ? edge_vals[$urandom_range(4)] : 32'($urandom);
      q = ($urandom_range(3) == 0) ? edge_vals[$urandom_range(4)] : 32'($urandom);
      start_op(m, q);
      wait_done(0, n);
      n_cmp++;
      if (n != LAT || result !== ref_product(m, q)) begin
        n_bad++;
        $display("FAIL random[%0d]: M=%h Q=%h cycles=%0d result=%h required cycles=%0d result=%h", k, m, q, n, result, LAT, ref_product(m, q));
      end
      do_clear();
    end
  endtask

  task automatic test_reset_mid_exec();
    int saw = 0;
    int n;
    logic [2*W-1:0] req;
    start_op(32'hCAFE_0001, 32'h0000_1234);
    repeat (5) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if (op_done !== 1'b0 || result !== '0) begin
      n_bad++;
      $display("FAIL reset_mid_exec: op_done=%b result=%h required op_done=0 result=0", op_done, result);
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    for (int c = 0; c < 25; c++) begin
      @(posedge clk); #1;
      if (op_done) saw++;
    end
    n_cmp++;
    if (saw != 0) begin
      n_bad++;
      $display("FAIL reset_residual: done_cycles=%0d required=0", saw);
    end
    req = ref_product(32'hFFFF_FF9C, 32'h0001_0003);
    start_op(32'hFFFF_FF9C, 32'h0001_0003);
    wait_done(0, n);
    n_cmp++;
    if (n != LAT || result !== req) begin
      n_bad++;
      $display("FAIL after_reset_op: cycles=%0d result=%h required cycles=%0d result=%h", n, result, LAT, req);
    end
    // Reset while a product is held must clear it without waiting for a clock.
    #2;
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if (op_done !== 1'b0 || result !== '0) begin
      n_bad++;
      $display("FAIL reset_in_done: op_done=%b result=%h required op_done=0 result=0", op_done, result);
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_clear_mid_exec();
    test_clear_with_start();
    test_start_ignored();
    test_back_to_back();
    test_random();
    test_reset_mid_exec();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
